pc_redirect_unit: RTL and testbench
===================================

# pc_redirect_unit

Parametrised program-counter register and next-PC selector for the pipeline fetch stage. Chooses among sequential fetch (PC+4) and NSRC prioritised redirect sources (jump, branch, exception, …). Holds a pending redirect across fetch stalls so no redirect is lost. Issues a registered flush pulse to the IF/ID pipeline register on every accepted redirect.

## Interface
- WIDTH, 32, PC and target width in bits
- NSRC, 3, number of redirect sources; index 0 has the highest priority
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- IDXW, $clog2(NSRC) (min 1), width of the stored source index (derived localparam)

Ports:
- clk  in  1  rising-edge clock; the block uses this single clock
- rst  in  1  reset, synchronous, active-high
- stall  in  1  fetch stall; PC holds while high
- redirect_valid  in  NSRC  per-source redirect request, single-cycle pulse or level
- redirect_target  in  NSRC*WIDTH  packed targets; source i at bits [i*WIDTH +: WIDTH]
- pc  out  WIDTH  current fetch PC (registered)
- pc_plus4  out  WIDTH  pc + 4, combinational, modulo 2^WIDTH
- pending  out  1  a redirect is latched and waiting for stall release (registered)
- flush  out  1  one-cycle pulse, registered, following any accepted redirect

## Operation
- Live select: lowest set index in redirect_valid gives live_idx/live_tgt; live_hit = |redirect_valid.
- Pending register: pend_v, pend_idx (IDXW bits), pend_tgt (WIDTH bits).
- Per-cycle rules, evaluated in priority order:
  - rst: pc <= RESET_PC; pend_v <= 0; flush <= 0. Inputs ignored.
  - stall=1, live_hit, and (!pend_v or live_idx < pend_idx): capture pend_v<=1, pend_idx<=live_idx, pend_tgt<=live_tgt; flush<=1; pc holds.
  - stall=1 otherwise: pc and pending hold; flush<=0. A live redirect with index >= pend_idx is dropped.
  - stall=0, pend_v, and (!live_hit or live_idx >= pend_idx): pc<=pend_tgt; pend_v<=0; flush<=0. The flush for this redirect was already issued at capture.
  - stall=0, live_hit, and (!pend_v or live_idx < pend_idx): pc<=live_tgt; pend_v<=0; flush<=1.
  - stall=0, no live_hit, no pend_v: pc<=pc+4; flush<=0.
- Equal index: a live request from the same source as the pending one is treated as lower priority. The pending target wins; the new one is dropped.
- Arithmetic: pc+4 truncated to WIDTH; all-ones region wraps to 0 without error.
- Targets are used unaligned-as-given; no alignment checks.

## Timing
- Reset values: pc=RESET_PC, pending=0, flush=0. pc_plus4=RESET_PC+4 in the first cycle after reset.
- Redirect latency: a live redirect sampled at edge N (stall=0) makes pc=target and flush=1 after edge N. pc_plus4 follows in the same cycle.
- Stalled redirect: flush rises one cycle after capture. pc updates on the first edge where stall=0; pending drops on that same edge.
- flush is never high for more than one cycle per accepted redirect. Back-to-back accepted redirects give back-to-back flush cycles.
- rst asserted mid-stall with pending set: pending is cleared and the target is discarded.

## Structure
- Shared package/header `pipe_defs`: PC_INC (4), default RESET_PC, default WIDTH.
- One sub-module: `redirect_prio_enc` (parameters NSRC, WIDTH). Maps redirect_valid and redirect_target to live_hit, live_idx, live_tgt; purely combinational, lowest index wins.
- Top level holds the pc/pending/flush registers and the next-state logic.

## Test plan
- Reset then run 3 cycles, no requests:
  - pc sequence 0x0, 0x4, 0x8, 0xC
  - flush=0 throughout
- redirect_valid=3'b110 pulsed for 1 cycle, target1=0x100, target2=0x200, stall=0:
  - next pc=0x100, flush=1 for one cycle
  - then pc=0x104
- stall=1, pulse source 2 (0x200), then source 0 (0x40) two cycles later, then release stall:
  - pending=1 after first pulse; pend target becomes 0x40
  - flush pulses once per capture
  - on release pc=0x40, pending=0, flush=0
- stall=1 with pending from source 1 (0x300); release stall while source 2 (0x500) is live:
  - pc=0x300, since the pending entry wins
  - live source 2 is dropped
  - the following cycle pc=0x304
- WIDTH=8, RESET_PC=8'hF8, no requests:
  - pc sequence 0xF8, 0xFC, 0x00, 0x04
- rst asserted while stall=1 and pending=1:
  - next cycle pc=RESET_PC, pending=0, flush=0
  - after stall release, sequential fetch resumes from RESET_PC

Source files
------------

// File: rtl/pipe_defs.sv
// Shared fetch-stage definitions: PC increment, default geometry and the
// per-cycle action taken by the PC register.
package pipe_defs;

    localparam int          DEFAULT_WIDTH    = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          PC_INC           = 4;

    // What the PC/pending registers do on the next edge (reset is handled
    // separately because it overrides every input).
    typedef enum logic [2:0] {
        ACT_SEQ     = 3'd0,  // no redirect anywhere: fetch pc+4
        ACT_LIVE    = 3'd1,  // unstalled, live redirect wins: jump now and flush
        ACT_PEND    = 3'd2,  // unstalled, pending redirect wins: jump, flush already sent
        ACT_CAPTURE = 3'd3,  // stalled, live redirect beats what is stored: latch it and flush
        ACT_HOLD    = 3'd4   // stalled, nothing better arrived: hold everything
    } pc_action_e;

    // Width of a source index; a single source still needs one bit.
    function automatic int idx_width(input int nsrc);
        return (nsrc > 1) ? $clog2(nsrc) : 1;
    endfunction

endpackage

// File: rtl/redirect_prio_enc.sv
// Fixed-priority selector over the redirect sources: the lowest requesting
// index wins and its target is forwarded. Purely combinational.
module redirect_prio_enc
    import pipe_defs::*;
#(
    parameter  int NSRC  = 3,
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int IDXW  = idx_width(NSRC)
) (
    input  logic [NSRC-1:0]       redirect_valid,
    input  logic [NSRC*WIDTH-1:0] redirect_target,
    output logic                  live_hit,
    output logic [IDXW-1:0]       live_idx,
    output logic [WIDTH-1:0]      live_tgt
);

    // Scan from the lowest-priority source upward so the lowest index is the last writer.
    always_comb begin
        // NOTE: every output gets a default before the loop; without it an
        // idle cycle would leave the outputs unassigned and infer latches.
        live_hit = 1'b0;
        live_idx = '0;
        live_tgt = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (redirect_valid[i]) begin
                live_hit = 1'b1;
                live_idx = IDXW'(i);
                live_tgt = redirect_target[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch-stage PC register with prioritised redirects. A redirect seen while
// fetch is stalled is parked in a one-entry pending slot (better-priority
// arrivals replace it) and applied on the first unstalled edge. Every
// accepted redirect produces exactly one registered flush pulse.
module pc_redirect_unit
    import pipe_defs::*;
#(
    parameter  int               WIDTH    = DEFAULT_WIDTH,
    parameter  int               NSRC     = 3,
    parameter  logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC),
    localparam int               IDXW     = idx_width(NSRC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic [NSRC-1:0]       redirect_valid,
    input  logic [NSRC*WIDTH-1:0] redirect_target,
    output logic [WIDTH-1:0]      pc,
    output logic [WIDTH-1:0]      pc_plus4,
    output logic                  pending,
    output logic                  flush
);

    logic             live_hit;
    logic [IDXW-1:0]  live_idx;
    logic [WIDTH-1:0] live_tgt;
    logic             live_wins;
    pc_action_e       action;

    logic [WIDTH-1:0] pc_q,       pc_d;
    logic             pend_v_q,   pend_v_d;
    logic [IDXW-1:0]  pend_idx_q, pend_idx_d;
    logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
    logic             flush_q,    flush_d;

    redirect_prio_enc #(
        .NSRC  (NSRC),
        .WIDTH (WIDTH)
    ) u_prio_enc (
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .live_hit        (live_hit),
        .live_idx        (live_idx),
        .live_tgt        (live_tgt)
    );

    // Sequential fetch address; wraps modulo 2^WIDTH by truncation.
    assign pc_plus4 = pc_q + WIDTH'(PC_INC);

    // Decide the action: a live request only beats a stored one with a strictly
    // smaller index, so a repeat from the same source never displaces it.
    always_comb begin
        live_wins = live_hit && (!pend_v_q || (live_idx < pend_idx_q));
        if (stall) begin
            action = live_wins ? ACT_CAPTURE : ACT_HOLD;
        end else if (live_wins) begin
            action = ACT_LIVE;
        end else if (pend_v_q) begin
            action = ACT_PEND;
        end else begin
            action = ACT_SEQ;
        end
    end

    // Next-state values for the PC, the pending slot and the flush pulse.
    always_comb begin
        pc_d       = pc_q;
        pend_v_d   = pend_v_q;
        pend_idx_d = pend_idx_q;
        pend_tgt_d = pend_tgt_q;
        flush_d    = 1'b0;
        unique case (action)
            ACT_SEQ: begin
                pc_d = pc_plus4;
            end
            ACT_LIVE: begin
                pc_d     = live_tgt;
                pend_v_d = 1'b0;
                flush_d  = 1'b1;
            end
            ACT_PEND: begin
                // The flush for this redirect went out when it was captured.
                pc_d     = pend_tgt_q;
                pend_v_d = 1'b0;
            end
            ACT_CAPTURE: begin
                pend_v_d   = 1'b1;
                pend_idx_d = live_idx;
                pend_tgt_d = live_tgt;
                flush_d    = 1'b1;
            end
            ACT_HOLD: begin
                // Everything holds; a live request that does not beat the stored one is dropped.
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
    end

    // State registers; reset restarts fetch at RESET_PC and discards any pending redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: only the control bits are reset. The pending index/target
            // are payload qualified by pend_v, so they need no reset value.
            pc_q     <= RESET_PC;
            pend_v_q <= 1'b0;
            flush_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge state, independent of statement order.
            pc_q     <= pc_d;
            pend_v_q <= pend_v_d;
            flush_q  <= flush_d;
        end
        pend_idx_q <= pend_idx_d;
        pend_tgt_q <= pend_tgt_d;
    end

    assign pc      = pc_q;
    assign pending = pend_v_q;
    assign flush   = flush_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench for pc_redirect_unit: directed scenarios with fixed
// expected values, then randomized traffic against a behavioural model.
module tb_pc_redirect_unit;

    localparam int W = 32;
    localparam int N = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           stall;
    logic [N-1:0]   redirect_valid;
    logic [N*W-1:0] redirect_target;
    logic [W-1:0]   pc, pc_plus4;
    logic           pending, flush;

    // Narrow instance for the wrap-around case; idle inputs, shares reset.
    logic           stall8 = 1'b0;
    logic [N-1:0]   valid8 = '0;
    logic [N*8-1:0] target8 = '0;
    logic [7:0]     pc8, pc8_plus4;
    logic           pending8, flush8;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [W-1:0] m_pc;
    bit           m_pend;
    int           m_src;
    logic [W-1:0] m_tgt;
    bit           m_flush;

    always #5 clk = ~clk;

    pc_redirect_unit #(.WIDTH(W), .NSRC(N), .RESET_PC(32'h0)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .pending         (pending),
        .flush           (flush)
    );

    pc_redirect_unit #(.WIDTH(8), .NSRC(N), .RESET_PC(8'hF8)) dut8 (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall8),
        .redirect_valid  (valid8),
        .redirect_target (target8),
        .pc              (pc8),
        .pc_plus4        (pc8_plus4),
        .pending         (pending8),
        .flush           (flush8)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [N*W-1:0] tgts(input logic [W-1:0] t0, input logic [W-1:0] t1,
                                            input logic [W-1:0] t2);
        return {t2, t1, t0};
    endfunction

    // Spec rules applied directly: the requesting source with the smallest
    // number is the candidate; it is taken only if nothing is stored or it is
    // strictly more urgent than the stored one.
    task automatic model_step(input bit r, input bit s, input logic [N-1:0] v,
                              input logic [N*W-1:0] t);
        int  cand;
        bit  better;
        logic [W-1:0] targets [N];
        for (int i = 0; i < N; i++) targets[i] = t[i*W +: W];
        if (r) begin
            m_pc = '0; m_pend = 0; m_flush = 0;
            return;
        end
        cand = -1;
        for (int i = 0; i < N; i++) if (v[i] && cand < 0) cand = i;
        better = (cand >= 0) && (!m_pend || cand < m_src);
        if (s) begin
            if (better) begin
                m_pend = 1; m_src = cand; m_tgt = targets[cand]; m_flush = 1;
            end else begin
                m_flush = 0;
            end
        end else if (better) begin
            m_pc = targets[cand]; m_pend = 0; m_flush = 1;
        end else if (m_pend) begin
            m_pc = m_tgt; m_pend = 0; m_flush = 0;
        end else begin
            m_pc = m_pc + 32'd4; m_flush = 0;
        end
    endtask

    // Apply one cycle of inputs, advance the model, and compare #1 after the edge.
    task automatic cycle(input bit r, input bit s, input logic [N-1:0] v,
                         input logic [N*W-1:0] t);
        rst = r; stall = s; redirect_valid = v; redirect_target = t;
        @(posedge clk);
        model_step(r, s, v, t);
        #1;
        check("model_pc",      pc,       m_pc);
        check("model_pc_plus4", pc_plus4, m_pc + 32'd4);
        check("model_pending", {31'b0, pending}, {31'b0, m_pend});
        check("model_flush",   {31'b0, flush},   {31'b0, m_flush});
    endtask

    initial begin
        logic [N*W-1:0] zt;
        zt = '0;
        rst = 1'b1; stall = 1'b0; redirect_valid = '0; redirect_target = '0;
        m_pc = '0; m_pend = 0; m_src = 0; m_tgt = '0; m_flush = 0;

        // Reset and sequential fetch; narrow instance wraps past 0xFC.
        cycle(1, 0, 3'b000, zt);
        check("rst_pc", pc, 32'h0);
        check("rst_pc_plus4", pc_plus4, 32'h4);
        check("rst_pending", {31'b0, pending}, 32'h0);
        check("rst_flush", {31'b0, flush}, 32'h0);
        check("w8_pc0", {24'b0, pc8}, 32'hF8);
        cycle(0, 0, 3'b000, zt);
        check("seq_pc1", pc, 32'h4);
        check("w8_pc1", {24'b0, pc8}, 32'hFC);
        cycle(0, 0, 3'b000, zt);
        check("seq_pc2", pc, 32'h8);
        check("w8_pc2", {24'b0, pc8}, 32'h00);
        cycle(0, 0, 3'b000, zt);
        check("seq_pc3", pc, 32'hC);
        check("seq_flush", {31'b0, flush}, 32'h0);
        check("w8_pc3", {24'b0, pc8}, 32'h04);

        // Two live sources at once: source 1 beats source 2.
        cycle(0, 0, 3'b110, tgts(32'h0, 32'h100, 32'h200));
        check("live_pc", pc, 32'h100);
        check("live_flush", {31'b0, flush}, 32'h1);
        cycle(0, 0, 3'b000, zt);
        check("live_after_pc", pc, 32'h104);
        check("live_after_flush", {31'b0, flush}, 32'h0);

        // Stalled capture, then upgrade by a more urgent source.
        cycle(0, 1, 3'b100, tgts(32'h0, 32'h0, 32'h200));
        check("cap_pending", {31'b0, pending}, 32'h1);
        check("cap_flush", {31'b0, flush}, 32'h1);
        check("cap_pc_hold", pc, 32'h104);
        cycle(0, 1, 3'b000, zt);
        check("cap_flush_once", {31'b0, flush}, 32'h0);
        cycle(0, 1, 3'b001, tgts(32'h40, 32'h0, 32'h0));
        check("upg_flush", {31'b0, flush}, 32'h1);
        cycle(0, 0, 3'b000, zt);
        check("rel_pc", pc, 32'h40);
        check("rel_pending", {31'b0, pending}, 32'h0);
        check("rel_flush", {31'b0, flush}, 32'h0);

        // Pending beats a less urgent live request on release.
        cycle(0, 1, 3'b010, tgts(32'h0, 32'h300, 32'h0));
        cycle(0, 0, 3'b100, tgts(32'h0, 32'h0, 32'h500));
        check("pend_win_pc", pc, 32'h300);
        check("pend_win_flush", {31'b0, flush}, 32'h0);
        cycle(0, 0, 3'b000, zt);
        check("pend_win_next", pc, 32'h304);

        // Same-source repeat while stalled is dropped.
        cycle(0, 1, 3'b010, tgts(32'h0, 32'h600, 32'h0));
        cycle(0, 1, 3'b010, tgts(32'h0, 32'h700, 32'h0));
        check("same_src_noflush", {31'b0, flush}, 32'h0);
        cycle(0, 0, 3'b000, zt);
        check("same_src_pc", pc, 32'h600);

        // Reset while stalled with a pending redirect.
        cycle(0, 1, 3'b001, tgts(32'h80, 32'h0, 32'h0));
        check("pre_rst_pending", {31'b0, pending}, 32'h1);
        cycle(1, 1, 3'b000, zt);
        check("mid_rst_pc", pc, 32'h0);
        check("mid_rst_pending", {31'b0, pending}, 32'h0);
        check("mid_rst_flush", {31'b0, flush}, 32'h0);
        cycle(0, 1, 3'b000, zt);
        check("post_rst_hold", pc, 32'h0);
        cycle(0, 0, 3'b000, zt);
        check("post_rst_seq", pc, 32'h4);

        // Randomized traffic, including wrap-around targets and rare resets.
        for (int k = 0; k < 600; k++) begin
            logic [N-1:0]   v;
            logic [N*W-1:0] t;
            bit s, r;
            s = ($urandom_range(0, 9) < 4);
            r = ($urandom_range(0, 63) == 0);
            v = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            for (int i = 0; i < N; i++)
                t[i*W +: W] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            cycle(r, s, v, t);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
